// File: rtl/hls_run_sequencer.sv
// Run controller for a Bambu "main" accelerator: reset, load, start, time, report per run.
// Optional per-run timeout is built when RUN_SEQ_TIMEOUT_EN is defined.
module hls_run_sequencer #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int CYC_W      = 32,
  parameter int RUNS_W     = 8,
  parameter int MAX_CYCLES = 200000000,
  parameter int RST_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [RUNS_W-1:0] cfg_runs,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_load_beats,
  output logic              busy,
  output logic              err,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_size,
  output logic              acc_rst_n,
  output logic              start_port,
  input  logic              done_port,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RUNS_W-1:0] res_run,
  output logic [1:0]        res_status,
  output logic [CYC_W-1:0]  res_cycles
);

  localparam int BPB   = DATA_W / 8;
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [1:0] ST_OK      = 2'b00;
`ifdef RUN_SEQ_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ARST, S_LOAD, S_START, S_RUN, S_REPORT
  } state_t;

  state_t            state_q, state_d;
  logic [RUNS_W-1:0] runs_q, runs_d, run_q, run_d;
  logic [ADDR_W-1:0] base_q, base_d, beats_q, beats_d;
  logic [ADDR_W-1:0] addr_q, addr_d, beat_cnt_q, beat_cnt_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic              busy_q, busy_d, err_q, err_d, ld_ready_q, ld_ready_d;
  logic              acc_rst_n_q, acc_rst_n_d, start_q, start_d;
  logic              res_valid_q, res_valid_d;
  logic [RUNS_W-1:0] res_run_q, res_run_d;
  logic [1:0]        res_status_q, res_status_d;
  logic [CYC_W-1:0]  res_cycles_q, res_cycles_d;
  logic              enter_arst, ld_hs;
  logic [RUNS_W:0]   run_next;

  assign ld_hs     = ld_valid && ld_ready_q;
  assign run_next  = {1'b0, run_q} + (RUNS_W+1)'(1);

  always_comb begin
    state_d      = state_q;
    runs_d       = runs_q;
    run_d        = run_q;
    base_d       = base_q;
    beats_d      = beats_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    cyc_d        = cyc_q;
    err_d        = err_q;
    res_run_d    = res_run_q;
    res_status_d = res_status_q;
    res_cycles_d = res_cycles_q;
    enter_arst   = 1'b0;
`ifdef RUN_SEQ_TIMEOUT_EN
    cyc_inc = cyc_q + CYC_W'(1);
`else
    cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
`endif

    case (state_q)
      S_IDLE: begin
        if (go && (cfg_runs != '0)) begin
          runs_d     = cfg_runs;
          base_d     = cfg_base_addr;
          beats_d    = cfg_load_beats;
          run_d      = '0;
          err_d      = 1'b0;
          enter_arst = 1'b1;
        end
      end
      S_ARST: begin
        if (rst_cnt_q == '0) begin
          beat_cnt_d = '0;
          state_d    = (beats_q == '0) ? S_START : S_LOAD;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      S_LOAD: begin
        if (ld_hs) begin
          addr_d     = addr_q + ADDR_W'(BPB);
          beat_cnt_d = beat_cnt_q + ADDR_W'(1);
          if (beat_cnt_q == beats_q - ADDR_W'(1)) state_d = S_START;
        end
      end
      S_START: begin
        cyc_d = CYC_W'(1);
        if (done_port) begin
          state_d      = S_REPORT;
          res_cycles_d = CYC_W'(1);
          res_status_d = ST_OK;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (done_port) begin
          state_d      = S_REPORT;
          res_cycles_d = cyc_inc;
          res_status_d = ST_OK;
`ifdef RUN_SEQ_TIMEOUT_EN
        end else if (cyc_inc == MAX_C) begin
          state_d      = S_REPORT;
          res_cycles_d = MAX_C;
          res_status_d = ST_TIMEOUT;
          err_d        = 1'b1;
`endif
        end else begin
          cyc_d = cyc_inc;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          if ((run_next < {1'b0, runs_q}) && (res_status_q == ST_OK)) begin
            run_d      = run_next[RUNS_W-1:0];
            enter_arst = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The write address restarts at the latched base for every run.
    if (enter_arst) begin
      state_d   = S_ARST;
      rst_cnt_d = RST_W'(RST_CYCLES - 1);
      addr_d    = base_d;
    end
    if ((state_d == S_REPORT) && (state_q != S_REPORT)) res_run_d = run_q;

    busy_d      = (state_d != S_IDLE);
    ld_ready_d  = (state_d == S_LOAD);
    start_d     = (state_d == S_START);
    res_valid_d = (state_d == S_REPORT);
    // Accelerator stays in reset after power-up until the first run releases it.
    if (state_d == S_ARST)      acc_rst_n_d = 1'b0;
    else if (state_d == S_IDLE) acc_rst_n_d = acc_rst_n_q;
    else                        acc_rst_n_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      runs_q       <= '0;
      run_q        <= '0;
      base_q       <= '0;
      beats_q      <= '0;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      rst_cnt_q    <= '0;
      cyc_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      ld_ready_q   <= 1'b0;
      acc_rst_n_q  <= 1'b0;
      start_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_run_q    <= '0;
      res_status_q <= '0;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      runs_q       <= runs_d;
      run_q        <= run_d;
      base_q       <= base_d;
      beats_q      <= beats_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      cyc_q        <= cyc_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      ld_ready_q   <= ld_ready_d;
      acc_rst_n_q  <= acc_rst_n_d;
      start_q      <= start_d;
      res_valid_q  <= res_valid_d;
      res_run_q    <= res_run_d;
      res_status_q <= res_status_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign busy       = busy_q;
  assign err        = err_q;
  assign ld_ready   = ld_ready_q;
  assign mem_we     = ld_hs;
  assign mem_addr   = addr_q;
  assign mem_wdata  = ld_ready_q ? ld_data : '0;
  assign mem_size   = 8'(DATA_W);
  assign acc_rst_n  = acc_rst_n_q;
  assign start_port = start_q;
  assign res_valid  = res_valid_q;
  assign res_run    = res_run_q;
  assign res_status = res_status_q;
  assign res_cycles = res_cycles_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Scoreboard bench for hls_run_sequencer: expected writes/records queued at issue, checked by a monitor.
module tb_hls_run_sequencer;

  localparam int AW = 14, DW = 16, CW = 6, RW = 8, MAXC = 50, RSTC = 2;

  logic          clock, reset, go;
  logic [RW-1:0] cfg_runs;
  logic [AW-1:0] cfg_base_addr, cfg_load_beats;
  logic          busy, err, ld_valid, ld_ready, mem_we;
  logic [DW-1:0] ld_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_size;
  logic          acc_rst_n, start_port, done_port, res_valid, res_ready;
  logic [RW-1:0] res_run;
  logic [1:0]    res_status;
  logic [CW-1:0] res_cycles;

  hls_run_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CYC_W(CW), .RUNS_W(RW),
                      .MAX_CYCLES(MAXC), .RST_CYCLES(RSTC)) dut (
    .clock(clock), .reset(reset), .go(go), .cfg_runs(cfg_runs),
    .cfg_base_addr(cfg_base_addr), .cfg_load_beats(cfg_load_beats),
    .busy(busy), .err(err), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .acc_rst_n(acc_rst_n), .start_port(start_port), .done_port(done_port),
    .res_valid(res_valid), .res_ready(res_ready), .res_run(res_run),
    .res_status(res_status), .res_cycles(res_cycles));

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [RW-1:0] run; logic [1:0] st; logic [CW-1:0] cyc; } rec_t;

  wr_t           exp_wr[$];
  rec_t          exp_rec[$];
  logic [DW-1:0] beat_q[$];
  int n_checks = 0, n_fail = 0;
  int done_delay = -1, stall_n = 0;
  int starts_seen = 0, wr_seen = 0;
  bit take_pending = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load stream source: presents queued beats, drops one after each handshake.
  initial begin
    ld_valid = 0; ld_data = '0;
    forever begin
      @(negedge clock);
      if (take_pending && beat_q.size() > 0) void'(beat_q.pop_front());
      if (beat_q.size() > 0) begin ld_valid = 1; ld_data = beat_q[0]; end
      else begin ld_valid = 0; ld_data = '0; end
      take_pending = ld_valid && ld_ready && reset;
    end
  end

  // Accelerator model: done_delay cycles after the start cycle (0 = same cycle, -1 = never).
  initial begin
    int acc_cnt;
    acc_cnt = -1; done_port = 0;
    forever begin
      @(negedge clock);
      if (!acc_rst_n) begin acc_cnt = -1; done_port = 0; end
      else begin
        if (start_port) acc_cnt = 0;
        else if (acc_cnt >= 0) acc_cnt++;
        done_port = (acc_cnt >= 0) && (done_delay >= 0) && (acc_cnt == done_delay);
        if (done_port) acc_cnt = -1;
      end
    end
  end

  // Result sink: holds res_ready low for stall_n cycles of every record.
  initial begin
    int stall_cnt;
    stall_cnt = 0; res_ready = 1;
    forever begin
      @(negedge clock);
      if (!res_valid) begin res_ready = (stall_n == 0); stall_cnt = 0; end
      else if (stall_cnt < stall_n) begin res_ready = 0; stall_cnt++; end
      else res_ready = 1;
    end
  end

  // Monitor: compares every write and record against the scoreboard queues.
  initial begin
    int low_cnt, hi_cnt;
    wr_t w; rec_t r;
    low_cnt = 0; hi_cnt = 0;
    forever begin
      @(negedge clock); #1;
      if (mem_we) begin
        if (exp_wr.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 0);
        else begin
          w = exp_wr.pop_front();
          $display("WR   addr=%h data=%h", mem_addr, mem_wdata);
          check("wr_addr", mem_addr, w.a);
          check("wr_data", mem_wdata, w.d);
          wr_seen++;
        end
      end
      if (res_valid) begin
        if (exp_rec.size() == 0) check("unexpected_record", {res_run, res_status, res_cycles}, 0);
        else begin
          r = exp_rec[0];
          check("rec_run", res_run, r.run);
          check("rec_status", res_status, r.st);
          check("rec_cycles", res_cycles, r.cyc);
          if (res_ready) begin
            $display("REC  run=%0d status=%0d cycles=%0d", res_run, res_status, res_cycles);
            void'(exp_rec.pop_front());
          end
        end
      end
      if (!reset || !busy) low_cnt = 0;
      else if (!acc_rst_n) low_cnt++;
      else if (low_cnt != 0) begin check("acc_rst_low_cycles", low_cnt, RSTC); low_cnt = 0; end
      if (!reset) hi_cnt = 0;
      else if (start_port) hi_cnt++;
      else if (hi_cnt != 0) begin check("start_pulse_width", hi_cnt, 1); starts_seen++; hi_cnt = 0; end
    end
  end

  task automatic check_outputs_zero(string name);
    check(name, {busy, err, ld_ready, mem_we, mem_addr, mem_wdata, acc_rst_n, start_port,
                 res_valid, res_run, res_status, res_cycles}, 0);
  endtask

  task automatic wait_idle(string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (!busy && exp_rec.size() == 0 && exp_wr.size() == 0) break;
    end
    check({name, "_completion"}, (k < 2000), 1);
  endtask

  task automatic run_seq(string name, int runs, int base, int beats, int delay, int stall,
                         int exp_cyc, int exp_st, int exp_recs);
    int s0, w0;
    logic [AW-1:0] a;
    rec_t r;
    cfg_runs = RW'(runs); cfg_base_addr = AW'(base); cfg_load_beats = AW'(beats);
    done_delay = delay; stall_n = stall;
    for (int ri = 0; ri < exp_recs; ri++) begin
      for (int b = 0; b < beats; b++) begin
        wr_t w;
        a = AW'(base + 2 * b);
        w.a = a; w.d = DW'(16'hA000 + ri * 16 + b);
        beat_q.push_back(w.d);
        exp_wr.push_back(w);
      end
      r.run = RW'(ri); r.st = 2'(exp_st); r.cyc = CW'(exp_cyc);
      exp_rec.push_back(r);
    end
    s0 = starts_seen; w0 = wr_seen;
    @(negedge clock); go = 1;
    @(negedge clock); go = 0;
    wait_idle(name);
    check({name, "_starts"}, starts_seen - s0, exp_recs);
    check({name, "_writes"}, wr_seen - w0, exp_recs * beats);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, k;
    reset = 0; go = 0; cfg_runs = '0; cfg_base_addr = '0; cfg_load_beats = '0;
    repeat (2) @(negedge clock);
    check_outputs_zero("reset_outputs");
    @(negedge clock); reset = 1;
    @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_acc_rst_n", acc_rst_n, 0);

    // cfg_runs = 0 is ignored
    cfg_runs = '0; cfg_load_beats = AW'(2);
    @(negedge clock); go = 1;
    @(negedge clock); go = 0;
    check("zero_runs_busy", busy, 0);
    @(negedge clock);
    check("zero_runs_busy2", busy, 0);

    run_seq("single",    1, 'h100,  3, 9, 0, 10, 0, 1);
    run_seq("zero_load", 1, 'h100,  0, 0, 0,  1, 0, 1);
    run_seq("multi",     3, 'h200,  2, 4, 5,  5, 0, 3);
    run_seq("wrap",      1, 'h3FFE, 2, 2, 0,  3, 0, 1);
`ifdef RUN_SEQ_TIMEOUT_EN
    run_seq("timeout",   2, 'h040,  1, -1, 0, MAXC, 1, 1);
    check("timeout_err", err, 1);
    check("timeout_idle", busy, 0);
    cfg_runs = RW'(1); cfg_load_beats = '0; done_delay = 3;
    begin
      rec_t r;
      r.run = '0; r.st = 2'b00; r.cyc = CW'(4);
      exp_rec.push_back(r);
    end
    @(negedge clock); go = 1;
    @(negedge clock); go = 0;
    check("go_clears_err", err, 0);
    wait_idle("after_timeout");
`else
    run_seq("saturate",  1, 'h040,  0, 70, 0, 63, 0, 1);
    check("saturate_err", err, 0);
`endif

    // Reset in the middle of a 4-beat load after the first beat
    cfg_runs = RW'(1); cfg_base_addr = AW'('h080); cfg_load_beats = AW'(4);
    done_delay = 1; stall_n = 0;
    begin
      wr_t w;
      w.a = AW'('h080); w.d = 16'h5A5A;
      beat_q.push_back(w.d); exp_wr.push_back(w);
    end
    w0 = wr_seen;
    @(negedge clock); go = 1;
    @(negedge clock); go = 0;
    for (k = 0; k < 100; k++) begin
      @(negedge clock);
      if (wr_seen != w0) break;
    end
    check("midload_first_beat", wr_seen - w0, 1);
    @(negedge clock); #2;
    check("midload_busy_before_reset", busy, 1);
    reset = 0; #1;
    check_outputs_zero("midload_reset_outputs");
    beat_q.delete(); exp_wr.delete(); exp_rec.delete(); take_pending = 0;
    @(negedge clock); @(negedge clock); reset = 1;
    @(negedge clock);
    check("midload_idle_after_reset", busy, 0);
    run_seq("restart",   1, 'h080,  4, 1, 0,  2, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
